// File: rtl/tex_spi_pkg.sv
// Shared constants for the texture-flash SPI reader: FSM encoding, command
// byte and bit-count helpers derived from the address width.
package tex_spi_pkg;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CMD  = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_GAP  = 3'd4;

   localparam logic [7:0] CMD_READ_DEFAULT = 8'h03;
   localparam int         ADDR_W_DEFAULT   = 24;
   localparam int         CMD_BITS         = 8;
   localparam int         DATA_BITS        = 8;

   // Wide enough for the longest phase (command + address) without wrapping.
   function automatic int bit_cnt_w(input int addr_w);
      return $clog2(addr_w + CMD_BITS + 1);
   endfunction

endpackage

// File: rtl/tex_spi_shift.sv
// Generic MSB-first shift register with parallel load; serves as the
// command/address serializer and as the read-data deserializer.
module tex_spi_shift #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         shift,
   input  logic         sin,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= {q[W-2:0], sin};
      end
   end

endmodule

// File: rtl/tex_spi_reader.sv
// Single-byte 0x03 READ controller for the texture SPI flash; one request
// in flight, SPI mode 0 at clk/2, response returned as a one-cycle strobe.
module tex_spi_reader
   import tex_spi_pkg::*;
#(
   parameter int          ADDR_W   = ADDR_W_DEFAULT,
   parameter logic [7:0]  CMD_READ = CMD_READ_DEFAULT,
   parameter int          CS_GAP   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [7:0]        rsp_data,
   output logic              tex_csb,
   output logic              tex_sclk,
   output logic              tex_out0,
   output logic              tex_oeb0,
   input  logic [3:0]        tex_in
);

   localparam int CW = bit_cnt_w(ADDR_W);
   localparam int SW = CMD_BITS + ADDR_W;

   localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_BITS - 1);
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);

   logic [2:0]    state;
   logic          phase;
   logic [CW-1:0] cnt;
   logic          ready_q;
   logic [SW-1:0] tx_q;
   logic [7:0]    rx_q;
   logic [CW-1:0] last_bit;
   logic [2:0]    state_after;

   logic accept, active, driving, bit_end;
   assign accept  = req_valid && ready_q && (state == S_IDLE);
   assign active  = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
   assign driving = (state == S_CMD) || (state == S_ADDR);
   assign bit_end = active && phase;

   always_comb begin
      last_bit    = DATA_LAST;
      state_after = S_GAP;
      case (state)
         S_CMD: begin
            last_bit    = CMD_LAST;
            state_after = S_ADDR;
         end
         S_ADDR: begin
            last_bit    = ADDR_LAST;
            state_after = S_DATA;
         end
         default: ;
      endcase
   end

   tex_spi_shift #(.W(SW)) u_tx (
      .clk      (clk),
      .load     (accept),
      .load_val ({CMD_READ, req_addr}),
      .shift    (bit_end && driving),
      .sin      (1'b0),
      .q        (tx_q)
   );

   // MISO is launched by the flash on our own falling SCLK, so it is stable
   // at the clk edge that ends phase 1 and needs no synchroniser.
   tex_spi_shift #(.W(8)) u_rx (
      .clk      (clk),
      .load     (1'b0),
      .load_val (8'h00),
      .shift    (bit_end && (state == S_DATA)),
      .sin      (tex_in[1]),
      .q        (rx_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         phase     <= 1'b0;
         cnt       <= '0;
         ready_q   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               ready_q <= ~accept;
               if (accept) begin
                  state <= S_CMD;
                  cnt   <= '0;
                  phase <= 1'b0;
               end
            end
            S_CMD, S_ADDR, S_DATA: begin
               phase <= ~phase;
               if (phase) begin
                  if (cnt == last_bit) begin
                     cnt   <= '0;
                     state <= state_after;
                     if (state == S_DATA) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= {rx_q[6:0], tex_in[1]};
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            S_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt     <= '0;
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = ready_q;
   assign tex_csb   = ~active;
   assign tex_sclk  = phase;
   assign tex_oeb0  = ~driving;
   assign tex_out0  = driving & tx_q[SW-1];

   logic unused_bits;
   assign unused_bits = ^{tx_q[SW-2:0], rx_q[7], tex_in[3:2], tex_in[0]};

endmodule
